seq_divider_n: RTL and testbench

Parametrised sequential restoring divider: a single block holding both the control FSM and the datapath. It accepts a WIDTH-bit dividend and divisor on a Go pulse and retires one quotient bit per clock. It reports quotient and remainder with a one-cycle Done pulse, and flags divide-by-zero on Err. It is the calculator's divide engine and supersedes the fixed-width divider control/datapath pair.

---
 rtl/seq_divider_n.sv | 163 ++++++++++++++++
 tb/tb_seq_divider_n.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_n.sv
// seq_divider_n: sequential restoring divider, one quotient bit per clock.
// Optional signed mode (with FIX state) is enabled by defining DIV_SIGNED_EN.
module seq_divider_n #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             Go,
   input  logic             sgn,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             Busy,
   output logic             Done,
   output logic             Err
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ITER,
`ifdef DIV_SIGNED_EN
      FIX,
`endif
      DONE
   } state_t;

   state_t           st, st_n;
   logic [WIDTH-1:0] xs, xs_n, ys, ys_n, q_n, r_n;
   logic [WIDTH:0]   ra, ra_n, sh_ra;
   logic [CW-1:0]    cnt, cnt_n;
   logic             err, err_n;
   logic [1:0]       unused_bits;
`ifdef DIV_SIGNED_EN
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   logic             sgn_r, sgn_r_n, sx, sx_n, sy, sy_n;
`endif

   // ra[WIDTH] is only ever zero after a restore step; sgn is unused when unsigned
   assign unused_bits = {sgn, ra[WIDTH]};

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) st <= IDLE;
      else     st <= st_n;
   end

   always_comb begin
      st_n  = st;
      xs_n  = xs;
      ys_n  = ys;
      ra_n  = ra;
      cnt_n = cnt;
      err_n = err;
      q_n   = Q;
      r_n   = R;
      sh_ra = {ra[WIDTH-1:0], xs[WIDTH-1]};
`ifdef DIV_SIGNED_EN
      sgn_r_n = sgn_r;
      sx_n    = sx;
      sy_n    = sy;
`endif
      case (st)
         IDLE: begin
            if (Go) begin
               xs_n  = X;
               ys_n  = Y;
               err_n = 1'b0;
`ifdef DIV_SIGNED_EN
               sgn_r_n = sgn;
`endif
               st_n  = CHECK;
            end
         end
         CHECK: begin
            if (ys == '0) begin
               q_n   = '1;
               r_n   = xs;
               err_n = 1'b1;
               st_n  = DONE;
            end else begin
               ra_n  = '0;
               cnt_n = CW'(WIDTH);
               st_n  = ITER;
`ifdef DIV_SIGNED_EN
               sx_n  = sgn_r & xs[WIDTH-1];
               sy_n  = sgn_r & ys[WIDTH-1];
               if (sgn_r && xs[WIDTH-1]) xs_n = -xs;
               if (sgn_r && ys[WIDTH-1]) ys_n = -ys;
               err_n = sgn_r && (xs == MIN_NEG) && (ys == '1);
`endif
            end
         end
         ITER: begin
            if (sh_ra >= {1'b0, ys}) begin
               ra_n = sh_ra - {1'b0, ys};
               xs_n = {xs[WIDTH-2:0], 1'b1};
            end else begin
               ra_n = sh_ra;
               xs_n = {xs[WIDTH-2:0], 1'b0};
            end
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) begin
`ifdef DIV_SIGNED_EN
               st_n = FIX;
`else
               // Results are loaded on entry to DONE so they are valid alongside Done
               q_n  = xs_n;
               r_n  = ra_n[WIDTH-1:0];
               st_n = DONE;
`endif
            end
         end
`ifdef DIV_SIGNED_EN
         FIX: begin
            q_n  = (sx ^ sy) ? -xs : xs;
            r_n  = sx ? -ra[WIDTH-1:0] : ra[WIDTH-1:0];
            st_n = DONE;
         end
`endif
         DONE:    st_n = IDLE;
         default: st_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         xs  <= '0;
         ys  <= '0;
         ra  <= '0;
         cnt <= '0;
         err <= 1'b0;
         Q   <= '0;
         R   <= '0;
`ifdef DIV_SIGNED_EN
         sgn_r <= 1'b0;
         sx    <= 1'b0;
         sy    <= 1'b0;
`endif
      end else begin
         xs  <= xs_n;
         ys  <= ys_n;
         ra  <= ra_n;
         cnt <= cnt_n;
         err <= err_n;
         Q   <= q_n;
         R   <= r_n;
`ifdef DIV_SIGNED_EN
         sgn_r <= sgn_r_n;
         sx    <= sx_n;
         sy    <= sy_n;
`endif
      end
   end

   always_comb begin
      Busy = (st != IDLE) && (st != DONE);
      Done = (st == DONE);
      Err  = (st == DONE) && err;
   end

endmodule

// File: tb/tb_seq_divider_n.sv
// Self-checking bench for seq_divider_n: vector table, Go-held/reset sequences,
// and random operands against an arithmetic reference model.
module tb_seq_divider_n;
   localparam int W = 8;
`ifdef DIV_SIGNED_EN
   localparam bit SGN_EN = 1'b1;
`else
   localparam bit SGN_EN = 1'b0;
`endif
   localparam int LAT  = SGN_EN ? W + 3 : W + 2;
   localparam int ZLAT = 2;

   logic         CLK = 1'b0;
   logic         rst, Go, sgn;
   logic [W-1:0] X, Y, Q, R;
   logic         Busy, Done, Err;
   int           vectors = 0;
   int           miscompares = 0;

   seq_divider_n #(.WIDTH(W)) dut (
      .CLK(CLK), .rst(rst), .Go(Go), .sgn(sgn), .X(X), .Y(Y),
      .Q(Q), .R(R), .Busy(Busy), .Done(Done), .Err(Err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic       s;
      logic [7:0] q;
      logic [7:0] r;
      logic       e;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Truncating division as plain integer arithmetic
   function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic s,
                                 output logic [7:0] q, output logic [7:0] r, output logic e);
      int xi, yi;
      e = 1'b0;
      if (y == 8'd0) begin
         q = 8'hFF;
         r = x;
         e = 1'b1;
      end else if (s && SGN_EN) begin
         xi = int'($signed(x));
         yi = int'($signed(y));
         if (xi == -128 && yi == -1) begin
            q = 8'h80;
            r = 8'h00;
            e = 1'b1;
         end else begin
            q = 8'(xi / yi);
            r = 8'(xi % yi);
         end
      end else begin
         q = x / y;
         r = x % y;
      end
   endfunction

   // Call at a negedge with the DUT idle; returns at the negedge of the Done cycle
   task automatic run_div(input logic [7:0] x, input logic [7:0] y, input logic s,
                          output logic [7:0] q, output logic [7:0] r, output logic e,
                          output int lat, output logic ctl_ok);
      Go = 1'b1; X = x; Y = y; sgn = s;
      @(posedge CLK);
      @(negedge CLK);
      Go = 1'b0; X = 8'($urandom); Y = 8'($urandom); sgn = 1'($urandom);
      lat = 0;
      ctl_ok = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         if (Done) begin
            lat = n;
            if (Busy) ctl_ok = 1'b0;
            break;
         end
         if (!Busy || Err) ctl_ok = 1'b0;
         @(negedge CLK);
      end
      q = Q; r = R; e = Err;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t       tbl[$];
      logic [7:0] q, r, mq, mr, x, y;
      logic       e, me, ok, s, seen;
      int         lat, n1, n2;

      rst = 1'b1; Go = 1'b0; sgn = 1'b0; X = '0; Y = '0;
      tbl.push_back('{8'd100, 8'd7,   1'b0, 8'd14,  8'd2, 1'b0});
      tbl.push_back('{8'd5,   8'd0,   1'b0, 8'd255, 8'd5, 1'b1});
      tbl.push_back('{8'd3,   8'd200, 1'b0, 8'd0,   8'd3, 1'b0});
      tbl.push_back('{8'd255, 8'd1,   1'b0, 8'd255, 8'd0, 1'b0});
      tbl.push_back('{8'd255, 8'd255, 1'b0, 8'd1,   8'd0, 1'b0});
      tbl.push_back('{8'd0,   8'd5,   1'b0, 8'd0,   8'd0, 1'b0});
      tbl.push_back('{8'd200, 8'd9,   1'b0, 8'd22,  8'd2, 1'b0});
      tbl.push_back('{8'd17,  8'd4,   1'b0, 8'd4,   8'd1, 1'b0});
`ifdef DIV_SIGNED_EN
      tbl.push_back('{8'h9C,  8'd7,   1'b1, 8'hF2,  8'hFE, 1'b0});
      tbl.push_back('{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00, 1'b1});
      tbl.push_back('{8'd100, 8'hF9,  1'b1, 8'hF2,  8'd2,  1'b0});
      tbl.push_back('{8'h9C,  8'd0,   1'b1, 8'hFF,  8'h9C, 1'b1});
      tbl.push_back('{8'h9C,  8'd7,   1'b0, 8'd22,  8'd2,  1'b0});
`else
      tbl.push_back('{8'h9C,  8'd7,   1'b1, 8'd22,  8'd2,  1'b0});
`endif

      repeat (2) @(negedge CLK);
      check("reset_Q", Q, 0);
      check("reset_R", R, 0);
      check("reset_Busy", Busy, 0);
      check("reset_Done", Done, 0);
      check("reset_Err", Err, 0);
      rst = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < tbl.size(); i++) begin
         run_div(tbl[i].x, tbl[i].y, tbl[i].s, q, r, e, lat, ok);
         check($sformatf("vec%0d_Q", i), q, tbl[i].q);
         check($sformatf("vec%0d_R", i), r, tbl[i].r);
         check($sformatf("vec%0d_Err", i), e, tbl[i].e);
         check($sformatf("vec%0d_latency", i), lat, (tbl[i].y == 8'd0) ? ZLAT : LAT);
         check($sformatf("vec%0d_busy_err_ctl", i), ok, 1);
         repeat (3) @(negedge CLK);
         check($sformatf("vec%0d_hold_Q", i), Q, tbl[i].q);
         check($sformatf("vec%0d_hold_R", i), R, tbl[i].r);
      end

      // Go held high across two divides: second accept only in the IDLE after Done
      Go = 1'b1; X = 8'd200; Y = 8'd9; sgn = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      X = 8'd17; Y = 8'd4;
      n1 = 0; n2 = 0;
      for (int n = 1; n <= 60; n++) begin
         if (Done && n1 == 0) begin
            n1 = n;
            check("held_first_Q", Q, 22);
            check("held_first_R", R, 2);
         end else if (Done) begin
            n2 = n;
            check("held_second_Q", Q, 4);
            check("held_second_R", R, 1);
            break;
         end
         if (n1 != 0 && n == n1 + 2) Go = 1'b0;
         if (n1 != 0 && n == n1 + 3) check("held_Q_kept_during_op", Q, 22);
         @(negedge CLK);
      end
      check("held_first_latency", n1, LAT);
      check("held_second_latency", n2, 2 * LAT + 1);
      @(negedge CLK);

      // Reset mid-operation aborts with all outputs cleared
      Go = 1'b1; X = 8'd100; Y = 8'd7;
      @(posedge CLK);
      @(negedge CLK);
      Go = 1'b0;
      repeat (4) @(negedge CLK);
      rst = 1'b1;
      #1;
      check("abort_Q", Q, 0);
      check("abort_R", R, 0);
      check("abort_Busy", Busy, 0);
      check("abort_Done", Done, 0);
      check("abort_Err", Err, 0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (Done || Busy) seen = 1'b1;
      end
      check("abort_quiet", seen, 0);
      rst = 1'b0;
      run_div(8'd100, 8'd7, 1'b0, q, r, e, lat, ok);
      check("after_rst_Q", q, 14);
      check("after_rst_R", r, 2);
      check("after_rst_latency", lat, LAT);

      for (int k = 0; k < 150; k++) begin
         x = 8'($urandom);
         y = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
         s = 1'($urandom);
         if (k < 3) begin
            x = 8'h80;
            y = 8'hFF;
            s = 1'b1;
         end
         model(x, y, s, mq, mr, me);
         @(negedge CLK);
         run_div(x, y, s, q, r, e, lat, ok);
         check($sformatf("rand%0d_Q(%0h/%0h s%0d)", k, x, y, s), q, mq);
         check($sformatf("rand%0d_R(%0h/%0h s%0d)", k, x, y, s), r, mr);
         check($sformatf("rand%0d_Err", k), e, me);
         check($sformatf("rand%0d_latency", k), lat, (y == 8'd0) ? ZLAT : LAT);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
